seq_shift_add_multiplier: RTL

//  Sequential unsigned N x N -> 2N shift-and-add multiplier; low-area counterpart to the array multiplier.

---
 rtl/mult_pkg.sv | 8 +
 rtl/bit16_Adder.sv | 22 ++
 rtl/seq_shift_add_multiplier.sv | 88 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int MULT_N = 16;

endpackage

// File: rtl/bit16_Adder.sv
// N-bit ripple-carry adder, carry-in tied low.
module bit16_Adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign S[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[N];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned N x N -> 2N multiplier, one partial product per cycle on a shared
// ripple adder; valid/ready on both sides, one operand pair in flight.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | N shift-add steps, cnt counts 0..N-1
// DONE  | product valid, waiting for out_ready
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  mult_state_t      state;
  logic [N-1:0]     acc;
  logic [N-1:0]     mq;
  logic [N-1:0]     mcand;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     add_b;
  logic [N-1:0]     s;
  logic             c;

  // A zero B operand turns the step into a plain shift when the multiplier bit is 0.
  assign add_b = mq[0] ? mcand : '0;

  bit16_Adder #(.N(N)) u_add (
    .A    (acc),
    .B    (add_b),
    .S    (s),
    .Cout (c)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Carry-out lands in the acc MSB after the right shift.
          acc <= {c, s[N-1:1]};
          mq  <= {s[0], mq[N-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            product <= {c, s, mq[N-1:1]};
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
